// File: rtl/pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit
//
// Hazard and forwarding controller for the 4-stage IF/ID -> EX -> MEM -> WB
// core. It keeps a shadow copy of the control fields of the instructions in
// EX, MEM and WB. From that copy and the ID instruction it derives:
//   - the load-use interlock,
//   - the multi-cycle EX hold,
//   - the taken-jump flush,
//   - the EX operand forwarding selects.
//
// Optional feature (compile-time macro ZERO_REG_EN):
//   defined   -> register 0 is hardwired to zero. It never matches, so it
//                never causes a stall and is never forwarded.
//   undefined -> register 0 behaves like any other register.
//
// Parameters:
//   RA_W   register address width
//   MC_LAT total EX occupancy of a multi-cycle op, legal range 2..15
//   CNT_W  multi-cycle counter width; 2**CNT_W must exceed MC_LAT
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   id_valid           ID holds a real instruction
//   id_src1, id_src2   ID source registers
//   id_dst             ID destination register
//   id_wreg            ID instruction writes a register
//   id_rmem            ID instruction is a load
//   id_multi           ID instruction is a multi-cycle EX op
//   ex_jmp             instruction in EX is a taken jump
//   stall_id           hold PC and the IF/ID register
//   hold_ex            hold the ID/EX register
//   bubble_ex          load a NOP into ID/EX
//   bubble_mem         load a NOP into EX/MEM
//   flush              kill IF/ID and ID/EX contents
//   fwd_a, fwd_b       EX operand selects:
//                        00 regfile, 01 EX/MEM result, 10 MEM/WB result
//   mc_busy            a multi-cycle op is occupying EX
//
// All outputs are combinational from the shadow state and the ID inputs.
// -----------------------------------------------------------------------------
module pipe_hazard_unit #(
  parameter int RA_W   = 4,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_src1,
  input  logic [RA_W-1:0] id_src2,
  input  logic [RA_W-1:0] id_dst,
  input  logic            id_wreg,
  input  logic            id_rmem,
  input  logic            id_multi,
  input  logic            ex_jmp,
  output logic            stall_id,
  output logic            hold_ex,
  output logic            bubble_ex,
  output logic            bubble_mem,
  output logic            flush,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            mc_busy
);

  // EX keeps everything needed for interlock and forwarding decisions.
  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] dst;
    logic            wreg;
    logic            rmem;
    logic            multi;
    logic [RA_W-1:0] src1;
    logic [RA_W-1:0] src2;
  } ex_entry_t;

  // MEM keeps the load flag only so that an impossible load hit can be flagged.
  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] dst;
    logic            wreg;
    logic            rmem;
  } mem_entry_t;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] dst;
    logic            wreg;
  } wb_entry_t;

  localparam ex_entry_t        EX_NOP  = '0;
  localparam mem_entry_t       MEM_NOP = '0;
  localparam wb_entry_t        WB_NOP  = '0;

  // The counter is loaded as the op enters EX. The first EX cycle is
  // therefore already busy, and the op leaves in the cycle the count is 0.
  localparam logic [CNT_W-1:0] MC_LOAD  = CNT_W'(MC_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ex_entry_t        ex_r;
  mem_entry_t       mem_r;
  wb_entry_t        wb_r;
  logic [CNT_W-1:0] mc_cnt_r;

  ex_entry_t        ex_nxt_s;
  mem_entry_t       mem_nxt_s;
  wb_entry_t        wb_nxt_s;
  logic [CNT_W-1:0] mc_cnt_nxt_s;

  ex_entry_t        id_entry_s;
  logic             mc_busy_s;
  logic             load_use_s;
  logic             jmp_multi_s;
  logic             mem_load_hit_s;

  // A stage supplies register s when it is a valid register-writing
  // instruction whose destination is s.
  function automatic logic reg_match(
    input logic [RA_W-1:0] s,
    input logic            v,
    input logic            w,
    input logic [RA_W-1:0] d
  );
`ifdef ZERO_REG_EN
    return v & w & (d == s) & (s != {RA_W{1'b0}});
`else
    return v & w & (d == s);
`endif
  endfunction

  // Youngest producer wins: MEM is checked before WB.
  function automatic logic [1:0] fwd_pick(
    input logic [RA_W-1:0] s,
    input mem_entry_t      m,
    input wb_entry_t       b
  );
    logic [1:0] sel;
    if (reg_match(s, m.valid, m.wreg, m.dst)) begin
      sel = 2'b01;
    end else if (reg_match(s, b.valid, b.wreg, b.dst)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Pack the ID fields into the form stored in EX.
  always_comb begin
    id_entry_s       = EX_NOP;
    id_entry_s.valid = id_valid;
    id_entry_s.dst   = id_dst;
    id_entry_s.wreg  = id_wreg;
    id_entry_s.rmem  = id_rmem;
    id_entry_s.multi = id_multi;
    id_entry_s.src1  = id_src1;
    id_entry_s.src2  = id_src2;
  end

  // Hazard detection and control outputs, priority flush > hold > load-use.
  always_comb begin
    mc_busy_s  = (mc_cnt_r != CNT_ZERO);
    load_use_s = id_valid & ex_r.rmem &
                 (reg_match(id_src1, ex_r.valid, ex_r.wreg, ex_r.dst) |
                  reg_match(id_src2, ex_r.valid, ex_r.wreg, ex_r.dst));

    flush      = ex_jmp;
    mc_busy    = mc_busy_s;
    stall_id   = 1'b0;
    hold_ex    = 1'b0;
    bubble_ex  = 1'b0;
    bubble_mem = 1'b0;

    if (ex_jmp) begin
      // The flush already discards ID, so stalling it would be pointless.
      stall_id   = 1'b0;
      bubble_ex  = 1'b0;
    end else if (mc_busy_s) begin
      // A pending load-use is simply re-evaluated once EX is released.
      stall_id   = 1'b1;
      hold_ex    = 1'b1;
      bubble_mem = 1'b1;
    end else if (load_use_s) begin
      stall_id   = 1'b1;
      bubble_ex  = 1'b1;
    end else begin
      stall_id   = 1'b0;
    end
  end

  // Forwarding selects, only meaningful while EX holds a real instruction.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_r.valid) begin
      fwd_a = fwd_pick(ex_r.src1, mem_r, wb_r);
      fwd_b = fwd_pick(ex_r.src2, mem_r, wb_r);
    end else begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end
  end

  // Next shadow state: WB always takes MEM; EX/MEM depend on the control.
  always_comb begin
    wb_nxt_s.valid = mem_r.valid;
    wb_nxt_s.dst   = mem_r.dst;
    wb_nxt_s.wreg  = mem_r.wreg;

    mem_nxt_s.valid = ex_r.valid;
    mem_nxt_s.dst   = ex_r.dst;
    mem_nxt_s.wreg  = ex_r.wreg;
    mem_nxt_s.rmem  = ex_r.rmem;

    ex_nxt_s     = id_entry_s;
    mc_cnt_nxt_s = CNT_ZERO;

    if (flush) begin
      // The jump itself moves on to MEM; whatever followed it is killed.
      ex_nxt_s     = EX_NOP;
      mc_cnt_nxt_s = CNT_ZERO;
    end else if (hold_ex) begin
      ex_nxt_s     = ex_r;
      mem_nxt_s    = MEM_NOP;
      mc_cnt_nxt_s = mc_cnt_r - CNT_ONE;
    end else if (bubble_ex) begin
      ex_nxt_s     = EX_NOP;
      mc_cnt_nxt_s = CNT_ZERO;
    end else if (id_valid & id_multi) begin
      ex_nxt_s     = id_entry_s;
      mc_cnt_nxt_s = MC_LOAD;
    end else begin
      ex_nxt_s     = id_entry_s;
      mc_cnt_nxt_s = CNT_ZERO;
    end
  end

  // Shadow pipeline and multi-cycle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r     <= EX_NOP;
      mem_r    <= MEM_NOP;
      wb_r     <= WB_NOP;
      mc_cnt_r <= CNT_ZERO;
    end else begin
      ex_r     <= ex_nxt_s;
      mem_r    <= mem_nxt_s;
      wb_r     <= wb_nxt_s;
      mc_cnt_r <= mc_cnt_nxt_s;
    end
  end

  // Conditions that the surrounding pipeline must never produce.
  always_comb begin
    jmp_multi_s    = ex_jmp & ex_r.valid & ex_r.multi;
    mem_load_hit_s = ex_r.valid & mem_r.rmem &
                     (reg_match(ex_r.src1, mem_r.valid, mem_r.wreg, mem_r.dst) |
                      reg_match(ex_r.src2, mem_r.valid, mem_r.wreg, mem_r.dst));
  end

  pipe_hazard_unit_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .jmp_multi    (jmp_multi_s),
    .mem_load_hit (mem_load_hit_s)
  );

endmodule

// -----------------------------------------------------------------------------
// pipe_hazard_unit_chk
//
// Assertion-only companion of pipe_hazard_unit. It flags two illegal
// situations:
//   - a taken jump while EX holds a multi-cycle op,
//   - a load in MEM whose result an EX instruction needs. The load-use
//     interlock is meant to prevent this.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   jmp_multi      ex_jmp asserted with a valid multi-cycle op in EX
//   mem_load_hit   valid EX source matches a load sitting in MEM
// -----------------------------------------------------------------------------
module pipe_hazard_unit_chk (
  input  logic clk,
  input  logic rst,
  input  logic jmp_multi,
  input  logic mem_load_hit
);

  // Sample the illegal conditions on every active edge outside reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!jmp_multi);
      assert (!mem_load_hit);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
`timescale 1ns/1ps
module tb_pipe_hazard_unit;
  localparam int RA_W   = 4;
  localparam int MC_LAT = 4;
  localparam int CNT_W  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [RA_W-1:0] id_src1, id_src2, id_dst;
  logic            id_wreg, id_rmem, id_multi, ex_jmp;
  logic            stall_id, hold_ex, bubble_ex, bubble_mem, flush, mc_busy;
  logic [1:0]      fwd_a, fwd_b;

  int checks = 0;
  int errors = 0;

  // Reference pipeline: st[0]=EX, st[1]=MEM, st[2]=WB.
  // A forward code equals the index of the producing stage.
  typedef struct { bit v; int dst; bit w; bit rm; bit mu; int s1; int s2; } ins_t;
  ins_t st[3];
  int   ex_age;   // cycles the current EX entry has spent in EX, 1 on entry
  bit   e_stall, e_hold, e_bex, e_bmem, e_flush, e_busy;
  int   e_fa, e_fb;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.RA_W(RA_W), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_dst(id_dst), .id_wreg(id_wreg), .id_rmem(id_rmem), .id_multi(id_multi),
    .ex_jmp(ex_jmp), .stall_id(stall_id), .hold_ex(hold_ex), .bubble_ex(bubble_ex),
    .bubble_mem(bubble_mem), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mc_busy(mc_busy)
  );

  function automatic bit writes(int s, ins_t e);
`ifdef ZERO_REG_EN
    if (s == 0) return 1'b0;
`endif
    return e.v && e.w && (e.dst == s);
  endfunction

  function automatic int fwd_of(int s);
    if (!st[0].v) return 0;
    for (int k = 1; k <= 2; k++) begin
      if (writes(s, st[k])) return k;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    bit lu;
    e_flush = ex_jmp;
    e_busy  = st[0].v && st[0].mu && (ex_age < MC_LAT);
    lu      = id_valid && st[0].rm && (writes(id_src1, st[0]) || writes(id_src2, st[0]));
    e_hold  = !e_flush && e_busy;
    e_bmem  = e_hold;
    e_stall = !e_flush && (e_busy || lu);
    e_bex   = !e_flush && !e_busy && lu;
    e_fa    = fwd_of(st[0].s1);
    e_fb    = fwd_of(st[0].s2);
  endtask

  task automatic model_advance();
    ins_t nop, idi;
    nop = '{default: 0};
    idi = '{v: id_valid, dst: id_dst, w: id_wreg, rm: id_rmem, mu: id_multi,
            s1: id_src1, s2: id_src2};
    if (rst) begin
      st[0] = nop; st[1] = nop; st[2] = nop; ex_age = 0;
    end else begin
      st[2] = st[1];
      if (e_flush) begin
        st[1] = st[0]; st[0] = nop; ex_age = 0;
      end else if (e_hold) begin
        st[1] = nop; ex_age++;
      end else if (e_bex) begin
        st[1] = st[0]; st[0] = nop; ex_age = 0;
      end else begin
        st[1] = st[0]; st[0] = idi; ex_age = 1;
      end
    end
  endtask

  task automatic check_all();
    model_eval();
    chk("stall_id",   {1'b0, stall_id},   {1'b0, e_stall});
    chk("hold_ex",    {1'b0, hold_ex},    {1'b0, e_hold});
    chk("bubble_ex",  {1'b0, bubble_ex},  {1'b0, e_bex});
    chk("bubble_mem", {1'b0, bubble_mem}, {1'b0, e_bmem});
    chk("flush",      {1'b0, flush},      {1'b0, e_flush});
    chk("mc_busy",    {1'b0, mc_busy},    {1'b0, e_busy});
    chk("fwd_a",      fwd_a,              2'(e_fa));
    chk("fwd_b",      fwd_b,              2'(e_fb));
  endtask

  // One clock: compare at negedge+1, then let state advance.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input int s1, input int s2, input int d,
                        input logic w, input logic rm, input logic mu, input logic jmp);
    id_valid = v;
    id_src1  = s1[RA_W-1:0];
    id_src2  = s2[RA_W-1:0];
    id_dst   = d[RA_W-1:0];
    id_wreg  = w;
    id_rmem  = rm;
    id_multi = mu;
    ex_jmp   = jmp;
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, {1'b0, stall_id},   2'b00);
    chk({tag, "_hold"},  {1'b0, hold_ex},    2'b00);
    chk({tag, "_bex"},   {1'b0, bubble_ex},  2'b00);
    chk({tag, "_bmem"},  {1'b0, bubble_mem}, 2'b00);
    chk({tag, "_flush"}, {1'b0, flush},      2'b00);
    chk({tag, "_busy"},  {1'b0, mc_busy},    2'b00);
    chk({tag, "_fa"},    fwd_a,              2'b00);
    chk({tag, "_fb"},    fwd_b,              2'b00);
  endtask

  initial begin
    bit held;
    rst = 1'b1;
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    model_advance();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all_zero("reset");
    tick();

    // Independent ALU ops: no hazards at all.
    set_in(1'b1, 2, 3, 1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 5, 6, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    #1; chk("ind_fa0", fwd_a, 2'b00); chk("ind_fb0", fwd_b, 2'b00);
    chk("ind_stall", {1'b0, stall_id}, 2'b00);
    tick();
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; chk("ind_fa1", fwd_a, 2'b00); chk("ind_fb1", fwd_b, 2'b00);
    idle(3);

    // Back-to-back dependency forwards from MEM.
    set_in(1'b1, 2, 3, 1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 1, 5, 4, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; chk("fwd_mem", fwd_a, 2'b01);
    idle(3);

    // One unrelated instruction in between forwards from WB.
    set_in(1'b1, 2, 3, 1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 8, 9, 7, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 1, 5, 4, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; chk("fwd_wb", fwd_a, 2'b10);
    idle(3);

    // Load-use: one stall/bubble cycle, then WB forwarding.
    set_in(1'b1, 2, 3, 1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    set_in(1'b1, 1, 5, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    #1; chk("lu_stall", {1'b0, stall_id}, 2'b01); chk("lu_bex", {1'b0, bubble_ex}, 2'b01);
    tick();
    #1; chk("lu_stall2", {1'b0, stall_id}, 2'b00); chk("lu_bex2", {1'b0, bubble_ex}, 2'b00);
    tick();
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; chk("lu_fwd", fwd_a, 2'b10); chk("lu_stall3", {1'b0, stall_id}, 2'b00);
    idle(3);

    // Multi-cycle op: busy for MC_LAT-1 cycles, then it reaches MEM.
    set_in(1'b1, 10, 11, 9, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    set_in(1'b1, 9, 13, 12, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < MC_LAT - 1; i++) begin
      #1;
      chk("mc_busy_on",  {1'b0, mc_busy},    2'b01);
      chk("mc_stall_on", {1'b0, stall_id},   2'b01);
      chk("mc_hold_on",  {1'b0, hold_ex},    2'b01);
      chk("mc_bmem_on",  {1'b0, bubble_mem}, 2'b01);
      tick();
    end
    #1; chk("mc_busy_off", {1'b0, mc_busy}, 2'b00); chk("mc_stall_off", {1'b0, stall_id}, 2'b00);
    tick();
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; chk("mc_in_mem", fwd_a, 2'b01);
    idle(3);

    // Taken jump overrides a pending load-use stall.
    set_in(1'b1, 2, 3, 1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    set_in(1'b1, 1, 5, 4, 1'b1, 1'b0, 1'b0, 1'b1);
    #1; chk("jmp_flush", {1'b0, flush}, 2'b01); chk("jmp_stall", {1'b0, stall_id}, 2'b00);
    chk("jmp_bex", {1'b0, bubble_ex}, 2'b00);
    tick();
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; chk("jmp_fa", fwd_a, 2'b00); chk("jmp_fb", fwd_b, 2'b00);
    chk("jmp_stall2", {1'b0, stall_id}, 2'b00); chk("jmp_flush2", {1'b0, flush}, 2'b00);
    idle(3);

    // Reset during the second hold cycle aborts the op.
    set_in(1'b1, 10, 11, 9, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    #1; chk_all_zero("mc_rst");
    idle(2);

    // Register 0 as a producer.
    set_in(1'b1, 2, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 0, 5, 4, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ZERO_REG_EN
    #1; chk("r0_fwd", fwd_a, 2'b00);
`else
    #1; chk("r0_fwd", fwd_a, 2'b01);
`endif
    idle(3);
    set_in(1'b1, 2, 3, 0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    set_in(1'b1, 0, 5, 4, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef ZERO_REG_EN
    #1; chk("r0_stall", {1'b0, stall_id}, 2'b00);
`else
    #1; chk("r0_stall", {1'b0, stall_id}, 2'b01);
`endif
    tick();
    idle(4);

    // Randomized traffic against the reference pipeline.
    held = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!held) begin
        id_valid = ($urandom_range(0, 7) != 0);
        id_src1  = RA_W'($urandom_range(0, 3));
        id_src2  = RA_W'($urandom_range(0, 3));
        id_dst   = RA_W'($urandom_range(0, 3));
        id_rmem  = ($urandom_range(0, 3) == 0);
        id_multi = !id_rmem && ($urandom_range(0, 9) == 0);
        id_wreg  = id_rmem || ($urandom_range(0, 3) != 0);
      end
      rst    = ($urandom_range(0, 63) == 0);
      ex_jmp = st[0].v && !st[0].mu && ($urandom_range(0, 7) == 0);
      tick();
      held = e_stall && !rst;
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the 4-stage IF/ID → EX → MEM → WB core.
- Keeps a shadow copy of the EX/MEM/WB control fields: valid, destination register, wreg, rmem, multi-cycle flag, and EX source registers.
- Generates stall, bubble, flush and forwarding selects.
- Replaces the fixed no-hazard pipeline; adds load-use interlock, taken-jump flush and multi-cycle EX ops.

Parameters:
- RA_W, 4, register address width (number of registers = 2**RA_W).
- MC_LAT, 4, total EX occupancy in cycles of a multi-cycle op (legal range 2..15).
- CNT_W, 4, width of the multi-cycle counter (must satisfy 2**CNT_W > MC_LAT).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  RA_W  first source register of the ID instruction.
- id_src2  in  RA_W  second source register of the ID instruction.
- id_dst  in  RA_W  destination register of the ID instruction.
- id_wreg  in  1  ID instruction writes a register.
- id_rmem  in  1  ID instruction is a load.
- id_multi  in  1  ID instruction is a multi-cycle EX op.
- ex_jmp  in  1  instruction in EX is a taken jump (wpc & jmp).
- stall_id  out  1  hold PC and the IF/ID register.
- hold_ex  out  1  hold the ID/EX register.
- bubble_ex  out  1  load a NOP into ID/EX.
- bubble_mem  out  1  load a NOP into EX/MEM.
- flush  out  1  kill IF/ID and ID/EX contents.
- fwd_a  out  2  EX operand A select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
- fwd_b  out  2  EX operand B select, same encoding.
- mc_busy  out  1  a multi-cycle op is occupying EX.

Behaviour:
- Reset:
  - All shadow entries invalid; mc counter = 0.
  - stall_id = hold_ex = bubble_ex = bubble_mem = flush = mc_busy = 0; fwd_a = fwd_b = 00 (outputs are combinational from cleared state).
  - Reset asserted mid multi-cycle op or mid stall aborts it; the first cycle after reset has no hazards.
- All outputs are combinational from the shadow state and the ID inputs. Shadow state updates on the rising clk edge.
- Match(s, E) = E.valid & E.wreg & (E.dst == s).
- Forwarding, for each EX source:
  - Match against MEM → 01.
  - Else match against WB → 10.
  - Else → 00.
  - MEM has priority over WB.
  - Computed only when the EX entry is valid; otherwise 00.
- Load-use:
  - Condition: id_valid and EX.rmem and (Match(id_src1, EX) or Match(id_src2, EX)).
  - Response: stall_id = 1 and bubble_ex = 1 for exactly 1 cycle.
- Multi-cycle op:
  - When a valid EX entry has multi = 1 and the counter is 0, load the counter with MC_LAT-1.
  - While the counter is nonzero: mc_busy = stall_id = hold_ex = bubble_mem = 1, and the counter decrements each cycle.
  - The op advances to MEM in the cycle the counter reaches 0.
  - The EX entry occupies EX for exactly MC_LAT cycles.
  - A load-use condition during mc_busy is re-evaluated after release.
- Taken jump:
  - On ex_jmp: flush = 1 for 1 cycle; the IF/ID and ID/EX contents are killed, giving a 2-instruction penalty.
  - The shadow EX entry becomes invalid next cycle.
  - The jump itself proceeds to MEM.
- Priority: flush > multi-cycle hold > load-use stall.
  - When flush = 1, stall_id = bubble_ex = 0 that cycle.
  - ex_jmp and an EX multi-cycle op together are illegal; flag with an assertion.
- Shadow advance:
  - Normal: WB ← MEM, MEM ← EX, EX ← ID fields (valid = id_valid).
  - bubble_ex: EX ← invalid.
  - hold_ex: EX keeps its value, MEM ← invalid.
  - flush: EX ← invalid.
- A MEM-stage load matching an EX source cannot occur, because the load-use interlock prevents it; flag it with an assertion.

Optional Feature:
- Macro: ZERO_REG_EN.
- Defined: register 0 is hardwired to zero. Match() is always false when s == 0, so no stall and no forwarding occur for register 0.
- Undefined: register 0 is treated like any other register.

Test Plan:
- Independent ALU ops, e.g. R1←R2+R3 then R4←R5+R6 → no stall; fwd_a = fwd_b = 00 throughout.
- R1←R2+R3, then R4←R1+R5 → second op in EX shows fwd_a = 01. With one unrelated instruction in between → fwd_a = 10.
- Load R1, then R4←R1+R5 → stall_id = bubble_ex = 1 for 1 cycle, then fwd_a = 10 with no further stall.
- Multi-cycle op with MC_LAT = 4 → mc_busy/stall_id/hold_ex/bubble_mem high for exactly 3 cycles; the op reaches MEM on cycle 4.
- ex_jmp pulse while ID holds a load-use-dependent instruction → flush = 1, stall_id = 0; next cycle EX shadow invalid and all forwards 00.
- rst asserted during the 2nd multi-cycle hold cycle → next cycle all outputs 0. With ZERO_REG_EN defined, R0 write then R0 read → fwd_a = 00 and no stall.
